// File: rtl/crp16_mem_arbiter_pkg.sv
// crp16_mem_arbiter_pkg: shared constants and helpers for the crp16 memory arbiter.
//   Port indices (F/D/G), lock state encoding, default aging limit,
//   counter width and the fixed D > F > G priority picker.
package crp16_mem_arbiter_pkg;

  localparam int unsigned PORT_F            = 0;
  localparam int unsigned PORT_D            = 1;
  localparam int unsigned PORT_G            = 2;
  localparam int unsigned N_PORTS           = 3;
  localparam int unsigned AGE_LIMIT_DEFAULT = 4;
  // Wide enough for the full 1..15 AGE_LIMIT range.
  localparam int unsigned AGE_W             = 4;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  // One-hot pick of the highest-priority set bit, order D > F > G.
  function automatic logic [N_PORTS-1:0] pick_prio(input logic [N_PORTS-1:0] elig);
    logic [N_PORTS-1:0] sel;
    sel = '0;
    if (elig[PORT_D])      sel[PORT_D] = 1'b1;
    else if (elig[PORT_F]) sel[PORT_F] = 1'b1;
    else if (elig[PORT_G]) sel[PORT_G] = 1'b1;
    return sel;
  endfunction

endpackage

// File: rtl/crp16_age_counter.sv
// crp16_age_counter: per-requester wait counter for starvation protection.
//   clock, resetn : clock and asynchronous active-low reset
//   req, gnt      : requester's request and this cycle's grant
//   starved       : age has reached AGE_LIMIT
module crp16_age_counter
  import crp16_mem_arbiter_pkg::*;
#(
  parameter int unsigned AGE_LIMIT = AGE_LIMIT_DEFAULT
) (
  input  logic clock,
  input  logic resetn,
  input  logic req,
  input  logic gnt,
  output logic starved
);

  logic [AGE_W-1:0] age_q;
  logic [AGE_W-1:0] age_d;

  // Count denied cycles, saturating at the limit; any grant or idle cycle clears.
  always_comb begin
    age_d = age_q;
    if (!req || gnt) begin
      age_d = '0;
    end else if (age_q != AGE_W'(AGE_LIMIT)) begin
      age_d = age_q + AGE_W'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) age_q <= '0;
    else         age_q <= age_d;
  end

  assign starved = (age_q == AGE_W'(AGE_LIMIT));

endmodule

// File: rtl/crp16_mem_arbiter.sv
// crp16_mem_arbiter: shares one single-port synchronous memory between
// instruction fetch (F), load/store (D) and debug/loader (G).
//   clock, resetn           : clock and asynchronous active-low reset
//   x_req/x_we/x_addr/x_wdata : per-port request and attributes (x = f, d, g)
//   g_lock                  : debug exclusive-access request
//   x_gnt                   : combinational grant, access issued this cycle
//   x_rvalid, rdata         : registered read-valid, read data straight from mem_q
//   locked                  : registered lock state
//   mem_*                   : memory macro interface
module crp16_mem_arbiter
  import crp16_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned AGE_LIMIT = AGE_LIMIT_DEFAULT
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              f_req,
  input  logic              d_req,
  input  logic              g_req,
  input  logic              f_we,
  input  logic              d_we,
  input  logic              g_we,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [ADDR_W-1:0] g_addr,
  input  logic [DATA_W-1:0] f_wdata,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [DATA_W-1:0] g_wdata,
  input  logic              g_lock,
  output logic              f_gnt,
  output logic              d_gnt,
  output logic              g_gnt,
  output logic              f_rvalid,
  output logic              d_rvalid,
  output logic              g_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              locked,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  output logic              mem_rden,
  input  logic [DATA_W-1:0] mem_q
);

  logic [N_PORTS-1:0] req;
  logic [N_PORTS-1:0] we;
  logic [N_PORTS-1:0] starved;
  logic [N_PORTS-1:0] elig;
  logic [N_PORTS-1:0] gnt;
  logic [ADDR_W-1:0]  addr  [N_PORTS];
  logic [DATA_W-1:0]  wdata [N_PORTS];

  lock_state_e        lock_q, lock_d;
  logic [N_PORTS-1:0] rvalid_q, rvalid_d;

  assign req = {g_req, d_req, f_req};
  assign we  = {g_we,  d_we,  f_we};

  assign addr[PORT_F]  = f_addr;
  assign addr[PORT_D]  = d_addr;
  assign addr[PORT_G]  = g_addr;
  assign wdata[PORT_F] = f_wdata;
  assign wdata[PORT_D] = d_wdata;
  assign wdata[PORT_G] = g_wdata;

  // Grant: starved eligible ports first, D > F > G inside each class.
  always_comb begin
    elig = req;
    if (lock_q == LOCKED) begin
      elig[PORT_F] = 1'b0;
      elig[PORT_D] = 1'b0;
    end
    if ((elig & starved) != '0) gnt = pick_prio(elig & starved);
    else                        gnt = pick_prio(elig);
    // Reset is asynchronous, so no access may leak out while it is held.
    if (!resetn) gnt = '0;
  end

  assign f_gnt = gnt[PORT_F];
  assign d_gnt = gnt[PORT_D];
  assign g_gnt = gnt[PORT_G];

  // Memory drive from the granted port; all zero when idle.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wren  = 1'b0;
    mem_rden  = 1'b0;
    for (int p = 0; p < int'(N_PORTS); p++) begin
      if (gnt[p]) begin
        mem_addr  = addr[p];
        mem_wdata = wdata[p];
        mem_wren  = we[p];
        mem_rden  = ~we[p];
      end
    end
  end

  // Lock next state; the release cycle itself still runs under lock rules.
  always_comb begin
    lock_d = lock_q;
    case (lock_q)
      UNLOCKED: if (gnt[PORT_G] && g_lock) lock_d = LOCKED;
      LOCKED:   if (!g_lock)               lock_d = UNLOCKED;
      default:  lock_d = UNLOCKED;
    endcase
  end

  // Read data returns one cycle after a read grant.
  always_comb begin
    rvalid_d = gnt & ~we;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      lock_q   <= UNLOCKED;
      rvalid_q <= '0;
    end else begin
      lock_q   <= lock_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign f_rvalid = rvalid_q[PORT_F];
  assign d_rvalid = rvalid_q[PORT_D];
  assign g_rvalid = rvalid_q[PORT_G];
  assign locked   = (lock_q == LOCKED);
  assign rdata    = mem_q;

  crp16_age_counter #(.AGE_LIMIT(AGE_LIMIT)) u_age_f (
    .clock   (clock),
    .resetn  (resetn),
    .req     (f_req),
    .gnt     (gnt[PORT_F]),
    .starved (starved[PORT_F])
  );

  crp16_age_counter #(.AGE_LIMIT(AGE_LIMIT)) u_age_d (
    .clock   (clock),
    .resetn  (resetn),
    .req     (d_req),
    .gnt     (gnt[PORT_D]),
    .starved (starved[PORT_D])
  );

  crp16_age_counter #(.AGE_LIMIT(AGE_LIMIT)) u_age_g (
    .clock   (clock),
    .resetn  (resetn),
    .req     (g_req),
    .gnt     (gnt[PORT_G]),
    .starved (starved[PORT_G])
  );

endmodule

// File: tb/tb_crp16_mem_arbiter.sv
// tb_crp16_mem_arbiter: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model of the arbitration rules.
`timescale 1ns/1ps
module tb_crp16_mem_arbiter;

  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned DATA_W    = 16;
  localparam int          AGE_LIMIT = 4;

  logic              clock = 1'b0;
  logic              resetn = 1'b0;
  logic              f_req, d_req, g_req;
  logic              f_we, d_we, g_we;
  logic [ADDR_W-1:0] f_addr, d_addr, g_addr;
  logic [DATA_W-1:0] f_wdata, d_wdata, g_wdata;
  logic              g_lock;
  logic              f_gnt, d_gnt, g_gnt;
  logic              f_rvalid, d_rvalid, g_rvalid;
  logic [DATA_W-1:0] rdata;
  logic              locked;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wren, mem_rden;
  logic [DATA_W-1:0] mem_q;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory macro model: synchronous, read data one cycle after mem_rden.
  logic [15:0] mem [0:255];

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_wren) mem[mem_addr[7:0]] <= mem_wdata;
    if (mem_rden) mem_q <= mem[mem_addr[7:0]];
  end

  crp16_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .AGE_LIMIT(AGE_LIMIT)) dut (
    .clock(clock), .resetn(resetn),
    .f_req(f_req), .d_req(d_req), .g_req(g_req),
    .f_we(f_we), .d_we(d_we), .g_we(g_we),
    .f_addr(f_addr), .d_addr(d_addr), .g_addr(g_addr),
    .f_wdata(f_wdata), .d_wdata(d_wdata), .g_wdata(g_wdata),
    .g_lock(g_lock),
    .f_gnt(f_gnt), .d_gnt(d_gnt), .g_gnt(g_gnt),
    .f_rvalid(f_rvalid), .d_rvalid(d_rvalid), .g_rvalid(g_rvalid),
    .rdata(rdata), .locked(locked),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wren(mem_wren), .mem_rden(mem_rden), .mem_q(mem_q)
  );

  // Behavioural model state for the random test.
  int          m_age [3];
  bit          m_lock;
  int          m_rv;
  logic [15:0] m_rd;
  logic [15:0] shadow [0:255];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    f_req = 0; d_req = 0; g_req = 0;
    f_we = 0; d_we = 0; g_we = 0;
    f_addr = '0; d_addr = '0; g_addr = '0;
    f_wdata = '0; d_wdata = '0; g_wdata = '0;
    g_lock = 0;
  endtask

  task automatic do_reset();
    resetn = 0;
    clear_inputs();
    tick();
    tick();
    resetn = 1;
  endtask

  // Index 0 = F, 1 = D, 2 = G. Starved ports win first, then D, F, G order.
  function automatic int model_pick(input logic [2:0] r);
    int order [3];
    order[0] = 1; order[1] = 0; order[2] = 2;
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < 3; k++) begin
        int p;
        p = order[k];
        if (r[p] && (!m_lock || p == 2) && (pass == 1 || m_age[p] == AGE_LIMIT)) return p;
      end
    end
    return -1;
  endfunction

  task automatic test_reset();
    resetn = 0;
    f_req = 1; d_req = 1; g_req = 1; g_lock = 1;
    #1;
    n_checks++; if ({g_gnt, d_gnt, f_gnt} !== 3'b000) begin n_fail++; $display("FAIL reset_gnt: got %b want 000", {g_gnt, d_gnt, f_gnt}); end
    n_checks++; if ({mem_wren, mem_rden} !== 2'b00) begin n_fail++; $display("FAIL reset_mem_en: got %b want 00", {mem_wren, mem_rden}); end
    tick();
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b want 0", locked); end
    n_checks++; if ({g_rvalid, d_rvalid, f_rvalid} !== 3'b000) begin n_fail++; $display("FAIL reset_rvalid: got %b want 000", {g_rvalid, d_rvalid, f_rvalid}); end
    clear_inputs();
    tick();
    resetn = 1;
  endtask

  task automatic test_basic_rw();
    do_reset();
    d_req = 1; d_we = 1; d_addr = 16'h0005; d_wdata = 16'hBEEF;
    #1;
    n_checks++; if (d_gnt !== 1'b1 || mem_wren !== 1'b1) begin n_fail++; $display("FAIL rw_write: d_gnt=%b mem_wren=%b want 1 1", d_gnt, mem_wren); end
    n_checks++; if (mem_addr !== 16'h0005 || mem_wdata !== 16'hBEEF) begin n_fail++; $display("FAIL rw_write_bus: addr=%h wdata=%h want 0005 beef", mem_addr, mem_wdata); end
    tick();
    d_req = 0;
    #1;
    n_checks++; if ({mem_wren, mem_rden} !== 2'b00 || mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin n_fail++; $display("FAIL rw_idle: en=%b addr=%h wdata=%h want 00 0 0", {mem_wren, mem_rden}, mem_addr, mem_wdata); end
    n_checks++; if ({g_rvalid, d_rvalid, f_rvalid} !== 3'b000) begin n_fail++; $display("FAIL rw_no_rvalid_after_write: got %b want 000", {g_rvalid, d_rvalid, f_rvalid}); end
    tick();
    d_req = 1; d_we = 0; d_addr = 16'h0005;
    #1;
    n_checks++; if (d_gnt !== 1'b1 || mem_rden !== 1'b1 || mem_wren !== 1'b0) begin n_fail++; $display("FAIL rw_read: d_gnt=%b rden=%b wren=%b want 1 1 0", d_gnt, mem_rden, mem_wren); end
    tick();
    d_req = 0;
    #1;
    n_checks++; if (d_rvalid !== 1'b1 || rdata !== 16'hBEEF) begin n_fail++; $display("FAIL rw_rdata: d_rvalid=%b rdata=%h want 1 beef", d_rvalid, rdata); end
    tick();
    n_checks++; if ({g_rvalid, d_rvalid, f_rvalid} !== 3'b000) begin n_fail++; $display("FAIL rw_rvalid_single_pulse: got %b want 000", {g_rvalid, d_rvalid, f_rvalid}); end
  endtask

  task automatic test_priority();
    do_reset();
    f_req = 1; f_addr = 16'h0001;
    d_req = 1; d_addr = 16'h0002;
    g_req = 1; g_addr = 16'h0003; g_lock = 1;
    #1;
    n_checks++; if ({g_gnt, d_gnt, f_gnt} !== 3'b010) begin n_fail++; $display("FAIL prio_d_first: got %b want 010", {g_gnt, d_gnt, f_gnt}); end
    n_checks++; if (mem_addr !== 16'h0002) begin n_fail++; $display("FAIL prio_addr: got %h want 0002", mem_addr); end
    tick();
    #1;
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL prio_lock_without_gnt: got %b want 0", locked); end
    n_checks++; if ({g_gnt, d_gnt, f_gnt} !== 3'b010) begin n_fail++; $display("FAIL prio_d_again: got %b want 010", {g_gnt, d_gnt, f_gnt}); end
    n_checks++; if ({g_rvalid, d_rvalid, f_rvalid} !== 3'b010) begin n_fail++; $display("FAIL prio_rvalid: got %b want 010", {g_rvalid, d_rvalid, f_rvalid}); end
    clear_inputs();
    tick();
  endtask

  task automatic test_starvation();
    do_reset();
    d_req = 1; d_we = 1; d_addr = 16'h0030; d_wdata = 16'h1111;
    f_req = 1; f_we = 1; f_addr = 16'h0031; f_wdata = 16'h2222;
    for (int c = 0; c < 6; c++) begin
      logic [2:0] exp_g;
      exp_g = (c == 4) ? 3'b001 : 3'b010;
      #1;
      n_checks++; if ({g_gnt, d_gnt, f_gnt} !== exp_g) begin n_fail++; $display("FAIL starve_cycle%0d: got %b want %b", c, {g_gnt, d_gnt, f_gnt}, exp_g); end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_lock();
    do_reset();
    g_req = 1; g_we = 1; g_addr = 16'h0020; g_wdata = 16'h1234; g_lock = 1;
    #1;
    n_checks++; if (g_gnt !== 1'b1 || locked !== 1'b0) begin n_fail++; $display("FAIL lock_take: g_gnt=%b locked=%b want 1 0", g_gnt, locked); end
    tick();
    g_req = 0;
    d_req = 1; d_we = 0; d_addr = 16'h0020;
    for (int c = 1; c <= 5; c++) begin
      if (c == 2) begin f_req = 1; f_we = 1; f_addr = 16'h0021; f_wdata = 16'h5555; end
      if (c == 3) begin g_req = 1; g_we = 0; g_addr = 16'h0020; end
      if (c == 4) g_req = 0;
      if (c == 5) g_lock = 0;
      #1;
      n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_held_c%0d: locked=%b want 1", c, locked); end
      n_checks++; if ({d_gnt, f_gnt} !== 2'b00) begin n_fail++; $display("FAIL lock_block_c%0d: d_gnt=%b f_gnt=%b want 0 0", c, d_gnt, f_gnt); end
      if (c == 3) begin
        n_checks++; if (g_gnt !== 1'b1) begin n_fail++; $display("FAIL lock_g_access: g_gnt=%b want 1", g_gnt); end
      end
      if (c == 4) begin
        n_checks++; if (g_rvalid !== 1'b1 || rdata !== 16'h1234) begin n_fail++; $display("FAIL lock_g_read: g_rvalid=%b rdata=%h want 1 1234", g_rvalid, rdata); end
      end
      tick();
    end
    #1;
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_release: locked=%b want 0", locked); end
    n_checks++; if ({g_gnt, d_gnt, f_gnt} !== 3'b010) begin n_fail++; $display("FAIL lock_release_gnt: got %b want 010", {g_gnt, d_gnt, f_gnt}); end
    tick();
    d_req = 0;
    #1;
    n_checks++; if (d_rvalid !== 1'b1 || rdata !== 16'h1234) begin n_fail++; $display("FAIL lock_d_read: d_rvalid=%b rdata=%h want 1 1234", d_rvalid, rdata); end
    n_checks++; if (f_gnt !== 1'b1) begin n_fail++; $display("FAIL lock_f_exits_starved: f_gnt=%b want 1", f_gnt); end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    // Age G to 3 behind D so stale ages would show up after reset.
    d_req = 1; d_we = 1; d_addr = 16'h0040; d_wdata = 16'h0001;
    g_req = 1; g_we = 1; g_addr = 16'h0041; g_wdata = 16'h0002;
    repeat (3) tick();
    d_req = 0;
    f_req = 1; f_we = 0; f_addr = 16'h0040;
    #1;
    n_checks++; if (f_gnt !== 1'b1) begin n_fail++; $display("FAIL rmr_f_gnt: got %b want 1", f_gnt); end
    #1;
    resetn = 0;
    f_req = 0;
    #1;
    n_checks++; if ({g_gnt, d_gnt, f_gnt} !== 3'b000 || {mem_wren, mem_rden} !== 2'b00) begin n_fail++; $display("FAIL rmr_forced_idle: gnt=%b en=%b want 000 00", {g_gnt, d_gnt, f_gnt}, {mem_wren, mem_rden}); end
    tick();
    tick();
    resetn = 1;
    d_req = 1;
    #1;
    n_checks++; if (f_rvalid !== 1'b0 || locked !== 1'b0) begin n_fail++; $display("FAIL rmr_after_release: f_rvalid=%b locked=%b want 0 0", f_rvalid, locked); end
    for (int c = 0; c < 5; c++) begin
      logic [2:0] exp_g;
      exp_g = (c == 4) ? 3'b100 : 3'b010;
      #1;
      n_checks++; if ({g_gnt, d_gnt, f_gnt} !== exp_g) begin n_fail++; $display("FAIL rmr_age_clear_c%0d: got %b want %b", c, {g_gnt, d_gnt, f_gnt}, exp_g); end
      if (c == 0) begin
        n_checks++; if (f_rvalid !== 1'b0) begin n_fail++; $display("FAIL rmr_no_late_rvalid: f_rvalid=%b want 0", f_rvalid); end
      end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_pipelined_reads();
    logic [2:0]  eg [4];
    logic [2:0]  er [4];
    logic [15:0] ed [4];
    logic [2:0]  gv;
    eg = '{3'b010, 3'b001, 3'b100, 3'b000};
    er = '{3'b000, 3'b010, 3'b001, 3'b100};
    ed = '{16'h0000, 16'h000B, 16'h000A, 16'h000C};
    do_reset();
    mem[8'h10] = 16'h000A; mem[8'h11] = 16'h000B; mem[8'h12] = 16'h000C;
    f_req = 1; f_we = 0; f_addr = 16'h0010;
    d_req = 1; d_we = 0; d_addr = 16'h0011;
    g_req = 1; g_we = 0; g_addr = 16'h0012;
    for (int c = 0; c < 4; c++) begin
      #1;
      gv = {g_gnt, d_gnt, f_gnt};
      n_checks++; if (gv !== eg[c]) begin n_fail++; $display("FAIL pipe_gnt_c%0d: got %b want %b", c, gv, eg[c]); end
      n_checks++; if ({g_rvalid, d_rvalid, f_rvalid} !== er[c]) begin n_fail++; $display("FAIL pipe_rvalid_c%0d: got %b want %b", c, {g_rvalid, d_rvalid, f_rvalid}, er[c]); end
      if (c > 0) begin
        n_checks++; if (rdata !== ed[c]) begin n_fail++; $display("FAIL pipe_rdata_c%0d: got %h want %h", c, rdata, ed[c]); end
      end
      tick();
      if (eg[c][0]) f_req = 0;
      if (eg[c][1]) d_req = 0;
      if (eg[c][2]) g_req = 0;
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_random();
    logic        r  [3];
    logic        w  [3];
    logic [15:0] a  [3];
    logic [15:0] wd [3];
    logic        lk;
    int          e;
    logic [2:0]  exp_g, exp_rv;
    logic [15:0] exp_addr, exp_wdata;
    do_reset();
    for (int p = 0; p < 3; p++) begin r[p] = 0; w[p] = 0; a[p] = '0; wd[p] = '0; m_age[p] = 0; end
    lk = 0; m_lock = 0; m_rv = -1; m_rd = '0;
    for (int i = 0; i < 256; i++) shadow[i] = mem[i];
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int p = 0; p < 3; p++) begin
        if (!r[p] && $urandom_range(0, 1) == 1) begin
          r[p]  = 1'b1;
          w[p]  = 1'($urandom_range(0, 1));
          a[p]  = 16'($urandom_range(0, 15));
          wd[p] = 16'($urandom);
        end
      end
      if ($urandom_range(0, 7) == 0) lk = ~lk;
      f_req = r[0]; f_we = w[0]; f_addr = a[0]; f_wdata = wd[0];
      d_req = r[1]; d_we = w[1]; d_addr = a[1]; d_wdata = wd[1];
      g_req = r[2]; g_we = w[2]; g_addr = a[2]; g_wdata = wd[2];
      g_lock = lk;
      #1;
      e = model_pick({r[2], r[1], r[0]});
      exp_g = 3'b000; exp_addr = '0; exp_wdata = '0;
      if (e >= 0) begin exp_g[e] = 1'b1; exp_addr = a[e]; exp_wdata = wd[e]; end
      exp_rv = 3'b000;
      if (m_rv >= 0) exp_rv[m_rv] = 1'b1;
      n_checks++; if ({g_gnt, d_gnt, f_gnt} !== exp_g) begin n_fail++; $display("FAIL rnd_gnt cyc%0d: got %b want %b", cyc, {g_gnt, d_gnt, f_gnt}, exp_g); end
      n_checks++; if (mem_wren !== (e >= 0 && w[e]) || mem_rden !== (e >= 0 && !w[e])) begin n_fail++; $display("FAIL rnd_mem_en cyc%0d: wren=%b rden=%b", cyc, mem_wren, mem_rden); end
      n_checks++; if (mem_addr !== exp_addr || mem_wdata !== exp_wdata) begin n_fail++; $display("FAIL rnd_mem_bus cyc%0d: addr=%h wdata=%h want %h %h", cyc, mem_addr, mem_wdata, exp_addr, exp_wdata); end
      n_checks++; if (locked !== m_lock) begin n_fail++; $display("FAIL rnd_locked cyc%0d: got %b want %b", cyc, locked, m_lock); end
      n_checks++; if ({g_rvalid, d_rvalid, f_rvalid} !== exp_rv) begin n_fail++; $display("FAIL rnd_rvalid cyc%0d: got %b want %b", cyc, {g_rvalid, d_rvalid, f_rvalid}, exp_rv); end
      if (m_rv >= 0) begin
        n_checks++; if (rdata !== m_rd) begin n_fail++; $display("FAIL rnd_rdata cyc%0d: got %h want %h", cyc, rdata, m_rd); end
      end
      // Advance the model across the coming clock edge.
      m_rv = -1;
      if (e >= 0 && !w[e]) begin m_rv = e; m_rd = shadow[a[e][7:0]]; end
      if (e >= 0 && w[e]) shadow[a[e][7:0]] = wd[e];
      for (int p = 0; p < 3; p++) begin
        if (!r[p] || e == p)           m_age[p] = 0;
        else if (m_age[p] < AGE_LIMIT) m_age[p] = m_age[p] + 1;
      end
      if (!m_lock && e == 2 && lk) m_lock = 1;
      else if (m_lock && !lk)      m_lock = 0;
      tick();
      if (e >= 0) r[e] = 1'b0;
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 3 + 7);
    mem_q = '0;
    clear_inputs();
    test_reset();
    test_basic_rw();
    test_priority();
    test_starvation();
    test_lock();
    test_reset_mid_read();
    test_pipelined_reads();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete within 1 ms");
    $fatal(1);
  end

endmodule
